gen_ekg_zabrudzony: RTL and testbench

Synthetic "contaminated" ECG source for bench and FPGA testing of the adaptive-filter chain (Nexys Video, 100 MHz clock).
- Produces a periodic piecewise-linear PQRST beat.
- Adds 50 Hz mains interference, triangular baseline wander and optional LFSR noise.
- Emits one 24-bit signed sample per sample tick on data_out.
- Sits at the head of the datapath, feeding the filters under test.

---
 rtl/gen_ekg_zabrudzony.sv | 135 +++++++++++++
 tb/tb_gen_ekg_zabrudzony.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/gen_ekg_zabrudzony.sv
// gen_ekg_zabrudzony: synthetic contaminated ECG source with PQRST beat, 50 Hz mains and triangular
// baseline wander. It emits one saturated 24-bit sample every CLK_DIV clocks. Define GEN_EKG_NOISE_EN to add LFSR noise.
module gen_ekg_zabrudzony #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [23:0] data_out
);
    localparam int unsigned OUT_W = 24;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned N_W   = 10;
    localparam int unsigned K_W   = 5;
    localparam int unsigned M_W   = 12;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(999);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(19);
    localparam logic [M_W-1:0]   M_LAST   = M_W'(3999);

    localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sd8388607;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -32'sd8388608;

    logic [DIV_W-1:0] div_q, div_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [M_W-1:0]   m_q, m_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             tick_c;

    logic signed [ACC_W-1:0] beat_c, mains_c, wander_c, noise_c, sum_c;
    logic [OUT_W-1:0]        sat_c;

    // One triangular wave component, (H-|n-c|)*S inside the support and 0 outside it.
    function automatic logic signed [ACC_W-1:0] tri_f(input logic [N_W-1:0] n, input int c,
                                                      input int h, input int s);
        int d;
        d = int'(n) - c;
        if (d < 0) d = -d;
        return (d < h) ? ACC_W'((h - d) * s) : '0;
    endfunction

    function automatic logic signed [ACC_W-1:0] mains_f(input logic [K_W-1:0] k);
        logic signed [ACC_W-1:0] v;
        unique case (k)
            5'd1, 5'd9:   v = 32'sd30902;
            5'd2, 5'd8:   v = 32'sd58779;
            5'd3, 5'd7:   v = 32'sd80902;
            5'd4, 5'd6:   v = 32'sd95106;
            5'd5:         v = 32'sd100000;
            5'd11, 5'd19: v = -32'sd30902;
            5'd12, 5'd18: v = -32'sd58779;
            5'd13, 5'd17: v = -32'sd80902;
            5'd14, 5'd16: v = -32'sd95106;
            5'd15:        v = -32'sd100000;
            default:      v = '0;
        endcase
        return v;
    endfunction

    function automatic logic signed [ACC_W-1:0] wander_f(input logic [M_W-1:0] m);
        int d;
        d = int'(m) - 2000;
        if (d < 0) d = -d;
        return ACC_W'(100 * d - 100000);
    endfunction

`ifdef GEN_EKG_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb_c;

    assign lfsr_fb_c = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    // The low 12 LFSR bits are treated as a signed value and multiplied by 8.
    assign noise_c   = {{(ACC_W - 15){lfsr_q[11]}}, lfsr_q[11:0], 3'b000};
    assign lfsr_d    = tick_c ? {lfsr_q[14:0], lfsr_fb_c} : lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign noise_c = '0;
`endif

    // Sample composition and saturation, using the pre-tick indices.
    always_comb begin
        beat_c   = tri_f(n_q, 150, 50, 3000)
                 + tri_f(n_q, 250, 10, -10000)
                 + tri_f(n_q, 270, 10, 200000)
                 + tri_f(n_q, 290, 10, -20000)
                 + tri_f(n_q, 500, 80, 4000);
        mains_c  = mains_f(k_q);
        wander_c = wander_f(m_q);
        sum_c    = beat_c + mains_c + wander_c + noise_c;
        if (sum_c > SAT_MAX)      sat_c = 24'h7FFFFF;
        else if (sum_c < SAT_MIN) sat_c = 24'h800000;
        else                      sat_c = sum_c[OUT_W-1:0];
    end

    // The divider and the index counters only advance on the sample tick.
    always_comb begin
        tick_c = (div_q == DIV_LAST);
        div_d  = tick_c ? '0 : DIV_W'(div_q + 1'b1);
        n_d    = n_q;
        k_d    = k_q;
        m_d    = m_q;
        data_d = data_q;
        if (tick_c) begin
            n_d    = (n_q == N_LAST) ? '0 : N_W'(n_q + 1'b1);
            k_d    = (k_q == K_LAST) ? '0 : K_W'(k_q + 1'b1);
            m_d    = (m_q == M_LAST) ? '0 : M_W'(m_q + 1'b1);
            data_d = sat_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            n_q    <= '0;
            k_q    <= '0;
            m_q    <= '0;
            data_q <= '0;
        end else begin
            div_q  <= div_d;
            n_q    <= n_d;
            k_q    <= k_d;
            m_q    <= m_d;
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_gen_ekg_zabrudzony.sv
// Scoreboard bench for gen_ekg_zabrudzony. The stimulus drives randomized reset segments and
// queues the expected samples. The monitor checks each tick and verifies that the output holds between ticks.
module tb_gen_ekg_zabrudzony;
    localparam int unsigned CLK_DIV = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] data_out;

    gen_ekg_zabrudzony #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    logic [23:0] last_v = '0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (%h) exp=%0d (%h) t=%0t", name, $signed(act), act,
                     $signed(exp), exp, $time);
        end
    endtask

    // Reference model, built directly from the beat, mains, wander and noise definitions.
    function automatic int beat_ref(input int n);
        int cen[5] = '{150, 250, 270, 290, 500};
        int hw[5]  = '{50, 10, 10, 10, 80};
        int pk[5]  = '{150000, -100000, 2000000, -200000, 320000};
        int e = 0;
        for (int i = 0; i < 5; i++) begin
            int d = (n > cen[i]) ? n - cen[i] : cen[i] - n;
            if (d < hw[i]) e += (pk[i] / hw[i]) * (hw[i] - d);
        end
        return e;
    endfunction

    function automatic int mains_ref(input int k);
        int tbl[20] = '{0, 30902, 58779, 80902, 95106, 100000, 95106, 80902, 58779, 30902,
                        0, -30902, -58779, -80902, -95106, -100000, -95106, -80902, -58779, -30902};
        return tbl[k];
    endfunction

    function automatic int wander_ref(input int m);
        return 100 * ((m > 2000) ? m - 2000 : 2000 - m) - 100000;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic b;
        b = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], b};
    endfunction

    function automatic logic [23:0] sample_ref(input int j, input logic [15:0] l);
        int s;
        int nz = 0;
`ifdef GEN_EKG_NOISE_EN
        logic [11:0] lo;
        lo = l[11:0];
        nz = int'($signed(lo)) * 8;
`else
        if (l == 16'h0) nz = 0;
`endif
        s = beat_ref(j % 1000) + mains_ref(j % 20) + wander_ref(j % 4000) + nz;
        if (s > 8388607) s = 8388607;
        if (s < -8388608) s = -8388608;
        return 24'(s);
    endfunction

    // The monitor pops one expected sample per tick and checks that the output holds between ticks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                cyc    = 0;
                last_v = '0;
                chk("reset_hold", data_out, 24'h0);
            end else begin
                cyc++;
                if (cyc == int'(CLK_DIV)) begin
                    cyc = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tick_underflow got=%0d exp=none t=%0t", $signed(data_out), $time);
                    end else begin
                        last_v = exp_q.pop_front();
                        chk("tick_sample", data_out, last_v);
                    end
                end else begin
                    chk("between_ticks", data_out, last_v);
                end
            end
        end
    end

    task automatic run_segment(input int len, input bit abort_early);
        logic [15:0] l = 16'hACE1;
        int budget;
        @(negedge clk);
        for (int j = 0; j < len; j++) begin
            exp_q.push_back(sample_ref(j, l));
            l = lfsr_step(l);
        end
        reset = 1'b1;
        budget = abort_early ? int'($urandom_range(1, len * CLK_DIV - 1)) : len * int'(CLK_DIV) + 8;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!abort_early && exp_q.size() == 0) break;
        end
        if (!abort_early) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain got=%0d exp=0 pending samples", exp_q.size());
            end
        end
        // Assert reset between clock edges and expect the output to clear at once.
        #($urandom_range(1, 4));
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset", data_out, 24'h0);
        repeat ($urandom_range(2, 6)) @(negedge clk);
    endtask

    initial begin
        repeat (10) @(negedge clk);
        chk("reset_state", data_out, 24'h0);
        run_segment(12, 1'b0);
        run_segment(4005, 1'b0);
        run_segment(int'($urandom_range(100, 400)), 1'b1);
        run_segment(280, 1'b0);
        for (int i = 0; i < 2; i++) run_segment(int'($urandom_range(20, 600)), 1'b0);
        run_segment(int'($urandom_range(30, 200)), 1'b1);
        run_segment(5, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
